// File: rtl/ram_bus_arbiter.sv
// Two-requester arbiter for a single-port byte RAM with round-robin priority.
// Each request is one RAM access, an RD_LAT-cycle read wait when reading, and a one-cycle ack.
module ram_bus_arbiter #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 15
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic          a_ack,
  output logic [7:0]    a_rdata,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic          b_ack,
  output logic [7:0]    b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_ce,
  output logic          ram_rden,
  output logic          ram_wren,
  input  logic [7:0]    ram_q,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, ACK} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t     state;
  logic       gnt_b;
  logic       last_b;
  logic       wr_r;
  logic [1:0] wait_cnt;
  logic       pick_b;
  logic       pick_wr;

  // B wins when alone, or when both ask and A was granted last
  always_comb begin
    pick_b  = b_req && (!a_req || !last_b);
    pick_wr = pick_b ? b_wr : a_wr;
  end

  assign busy = (state != IDLE);

  // ram_addr/ram_wdata double as the registered request fields
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      gnt_b     <= 1'b0;
      last_b    <= 1'b1;
      wr_r      <= 1'b0;
      wait_cnt  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_ce    <= 1'b0;
      ram_rden  <= 1'b0;
      ram_wren  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            gnt_b     <= pick_b;
            last_b    <= pick_b;
            wr_r      <= pick_wr;
            ram_addr  <= pick_b ? b_addr : a_addr;
            ram_wdata <= pick_b ? b_wdata : a_wdata;
            ram_ce    <= 1'b1;
            ram_rden  <= ~pick_wr;
            ram_wren  <= pick_wr;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          ram_ce   <= 1'b0;
          ram_rden <= 1'b0;
          ram_wren <= 1'b0;
          wait_cnt <= '0;
          if (wr_r) begin
            a_ack <= ~gnt_b;
            b_ack <= gnt_b;
            state <= ACK;
          end else begin
            state <= RWAIT;
          end
        end
        RWAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            if (gnt_b) b_rdata <= ram_q;
            else       a_rdata <= ram_q;
            a_ack <= ~gnt_b;
            b_ack <= gnt_b;
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: table of request vectors checked through a scoreboard
// against a behavioural RAM, plus sequences for reset abort, address hold and RD_LAT=3.
module tb_ram_bus_arbiter;

  typedef struct {
    bit          is_b;
    bit          wr;
    logic [14:0] addr;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    int unsigned a_n;
    int unsigned b_n;
    bit          a_wr;
    bit          b_wr;
    logic [14:0] a_addr;
    logic [14:0] b_addr;
    logic [7:0]  a_wd;
    logic [7:0]  b_wd;
    bit          first_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        a_req, a_wr, b_req, b_wr, a_req3;
  logic [14:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        zero1 = 1'b0;
  logic [14:0] zero15 = '0;
  logic [7:0]  zero8 = '0;

  logic        a_ack1, b_ack1, ram_ce1, ram_rden1, ram_wren1, busy1;
  logic [7:0]  a_rdata1, b_rdata1, ram_wdata1, q1;
  logic [14:0] ram_addr1;

  logic        a_ack3, b_ack3, ram_ce3, ram_rden3, ram_wren3, busy3;
  logic [7:0]  a_rdata3, b_rdata3, ram_wdata3, ram_q3;
  logic [14:0] ram_addr3;

  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  bit          sh_w[32768];
  logic [7:0]  sh_d[32768];
  bit          m_w[32768];
  logic [7:0]  m_d[32768];
  bit   [2:0]  p3;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.RD_LAT(1), .AW(15)) dut1 (
    .clk(clk), .n_rst(n_rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack1), .b_rdata(b_rdata1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_ce(ram_ce1), .ram_rden(ram_rden1),
    .ram_wren(ram_wren1), .ram_q(q1), .busy(busy1)
  );

  ram_bus_arbiter #(.RD_LAT(3), .AW(15)) dut3 (
    .clk(clk), .n_rst(n_rst),
    .a_req(a_req3), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack3), .a_rdata(a_rdata3),
    .b_req(zero1), .b_wr(zero1), .b_addr(zero15), .b_wdata(zero8), .b_ack(b_ack3), .b_rdata(b_rdata3),
    .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_ce(ram_ce3), .ram_rden(ram_rden3),
    .ram_wren(ram_wren3), .ram_q(ram_q3), .busy(busy3)
  );

  function automatic logic [7:0] init_val(input logic [14:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // RAM with one cycle of read latency for dut1
  always @(posedge clk) begin
    if (ram_ce1 && ram_wren1) begin
      m_w[ram_addr1] <= 1'b1;
      m_d[ram_addr1] <= ram_wdata1;
    end
    if (ram_ce1 && ram_rden1) q1 <= m_w[ram_addr1] ? m_d[ram_addr1] : init_val(ram_addr1);
  end

  // dut3 RAM: valid data only in the third cycle after the read strobe, garbage otherwise
  always @(posedge clk) p3 <= {p3[1:0], ram_ce3 & ram_rden3};
  assign ram_q3 = p3[2] ? 8'h96 : 8'h3C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen/missing, required the opposite", name);
  endtask

  task automatic push(input bit is_b, input bit wr, input logic [14:0] addr, input logic [7:0] wd);
    exp_t e;
    e.is_b = is_b;
    e.wr   = wr;
    e.addr = addr;
    if (wr) begin
      sh_w[addr] = 1'b1;
      sh_d[addr] = wd;
      e.data     = wd;
    end else begin
      e.data = sh_w[addr] ? sh_d[addr] : init_val(addr);
    end
    sbq.push_back(e);
  endtask

  task automatic wait_ack_a();
    int unsigned g = 0;
    while (!a_ack1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!a_ack1) fail("a_ack_timeout");
  endtask

  // Scoreboard: access fields checked against the head entry, popped on ack
  initial begin : mon
    exp_t        e;
    int unsigned cyc = 0, acc_cyc = 0, acc_n = 0;
    logic [7:0]  exp_ard = '0, exp_brd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!n_rst) begin
        acc_n   = 0;
        exp_ard = '0;
        exp_brd = '0;
      end else begin
        if (ram_ce1) begin
          if (sbq.size() == 0) fail("unexpected_access");
          else begin
            e = sbq[0];
            acc_n++;
            acc_cyc = cyc;
            chk("acc_wren", ram_wren1, e.wr);
            chk("acc_rden", ram_rden1, !e.wr);
            chk("acc_addr", ram_addr1, e.addr);
            if (e.wr) chk("acc_wdata", ram_wdata1, e.data);
          end
        end
        if (a_ack1 || b_ack1) begin
          chk("ack_overlap", a_ack1 && b_ack1, 0);
          if (sbq.size() == 0) fail("unexpected_ack");
          else begin
            e = sbq.pop_front();
            chk("ack_owner_b", b_ack1, e.is_b);
            chk("ack_latency", cyc - acc_cyc, e.wr ? 1 : 2);
            chk("access_count", acc_n, 1);
            acc_n = 0;
            if (!e.wr) begin
              if (e.is_b) exp_brd = e.data;
              else        exp_ard = e.data;
            end
            chk("a_rdata", a_rdata1, exp_ard);
            chk("b_rdata", b_rdata1, exp_brd);
          end
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int unsigned al = v.a_n, bl = v.b_n, guard = 0;
    bit nb = v.first_b;
    while (al + bl > 0) begin
      if (al > 0 && (bl == 0 || !nb)) begin
        push(1'b0, v.a_wr, v.a_addr, v.a_wd);
        al--;
        nb = 1'b1;
      end else begin
        push(1'b1, v.b_wr, v.b_addr, v.b_wd);
        bl--;
        nb = 1'b0;
      end
    end
    al = v.a_n;
    bl = v.b_n;
    a_wr = v.a_wr; a_addr = v.a_addr; a_wdata = v.a_wd;
    b_wr = v.b_wr; b_addr = v.b_addr; b_wdata = v.b_wd;
    a_req = (al > 0);
    b_req = (bl > 0);
    @(negedge clk);
    chk("grant_latency", ram_ce1, 1);
    while ((al > 0 || bl > 0) && guard < 100) begin
      @(negedge clk);
      guard++;
      if (a_ack1 && al > 0) begin al--; if (al == 0) a_req = 1'b0; end
      if (b_ack1 && bl > 0) begin bl--; if (bl == 0) b_req = 1'b0; end
    end
    if (al > 0 || bl > 0) fail("vector_timeout");
    repeat (2) @(negedge clk);
    chk("idle_busy", busy1, 0);
    chk("idle_ce", ram_ce1, 0);
    chk("sb_drained", sbq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int unsigned ack_k;
    n_rst = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_req3 = 1'b0;
    a_wr = 1'b0; b_wr = 1'b0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ce", ram_ce1, 0);
    chk("rst_rden", ram_rden1, 0);
    chk("rst_wren", ram_wren1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_rdata", {a_rdata1, b_rdata1}, 0);
    chk("rst_addr", ram_addr1, 0);
    n_rst = 1'b1;
    @(negedge clk);

    vecs[0] = '{1, 0, 1'b1, 1'b0, 15'h1234, 15'h0000, 8'h5A, 8'h00, 1'b0};
    vecs[1] = '{0, 1, 1'b0, 1'b0, 15'h0000, 15'h0099, 8'h00, 8'h00, 1'b1};
    vecs[2] = '{2, 2, 1'b1, 1'b1, 15'h0100, 15'h0200, 8'h11, 8'h22, 1'b0};
    vecs[3] = '{2, 2, 1'b0, 1'b0, 15'h0100, 15'h0200, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{1, 0, 1'b0, 1'b0, 15'h1234, 15'h0000, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{1, 1, 1'b1, 1'b1, 15'h7FFF, 15'h0000, 8'hFF, 8'h00, 1'b1};
    vecs[6] = '{0, 1, 1'b0, 1'b0, 15'h0000, 15'h7FFF, 8'h00, 8'h00, 1'b1};
    vecs[7] = '{1, 0, 1'b0, 1'b0, 15'h0000, 15'h0000, 8'h00, 8'h00, 1'b0};
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Request fields change right after grant; the RAM must keep the sampled ones
    push(1'b0, 1'b1, 15'h0ABC, 8'h77);
    a_wr = 1'b1; a_addr = 15'h0ABC; a_wdata = 8'h77; a_req = 1'b1;
    @(negedge clk);
    chk("hold_access", ram_ce1, 1);
    a_addr = 15'h0555; a_wdata = 8'h00; a_wr = 1'b0;
    #1;
    chk("hold_addr", ram_addr1, 15'h0ABC);
    chk("hold_wdata", ram_wdata1, 8'h77);
    wait_ack_a();
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    run_vec('{1, 0, 1'b0, 1'b0, 15'h0ABC, 15'h0000, 8'h00, 8'h00, 1'b0});

    // RD_LAT=3 instance
    a_wr = 1'b0; a_addr = 15'h0042; a_req3 = 1'b1;
    ack_k = 0;
    for (int k = 1; k <= 8 && ack_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) chk("rl3_rden", ram_rden3, 1);
      if (k == 4) chk("rl3_rwait_busy", busy3, 1);
      if (a_ack3) ack_k = k;
    end
    a_req3 = 1'b0;
    chk("rl3_latency", ack_k, 5);
    chk("rl3_rdata", a_rdata3, 8'h96);
    repeat (2) @(negedge clk);

    // Reset during RWAIT aborts; the held request is redone after release
    push(1'b0, 1'b0, 15'h0100, 8'h00);
    a_wr = 1'b0; a_addr = 15'h0100; a_wdata = 8'h33; a_req = 1'b1;
    @(negedge clk);
    chk("abort_access", ram_ce1, 1);
    @(negedge clk);
    chk("abort_rwait_busy", busy1, 1);
    n_rst = 1'b0;
    #1;
    chk("abort_busy", busy1, 0);
    chk("abort_ack", {a_ack1, b_ack1}, 0);
    chk("abort_addr", ram_addr1, 0);
    chk("abort_wdata", ram_wdata1, 0);
    chk("abort_rdata", {a_rdata1, b_rdata1}, 0);
    @(negedge clk);
    chk("abort_no_ack", a_ack1, 0);
    #2 n_rst = 1'b1;
    wait_ack_a();
    a_req = 1'b0;
    repeat (2) @(negedge clk);

    // Fresh reset, then both requesters rise together: A first, then alternate
    n_rst = 1'b0;
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    run_vec('{2, 2, 1'b0, 1'b0, 15'h0100, 15'h0200, 8'h00, 8'h00, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
RAM_BUS_ARBITER -- requirements
Module: ram_bus_arbiter

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 1, meaning RAM read latency in clk cycles from the ram_rden cycle to valid ram_q; legal range 1..3.
REQ-002 The block SHALL have parameter AW, default 15, meaning the RAM address width.
REQ-003 clk  input  1  single system clock (24 MHz); all state changes on its rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 a_req  input  1  requester A (CPU side) access request; level, held until a_ack.
REQ-006 a_wr  input  1  requester A direction: 1 write, 0 read.
REQ-007 a_addr  input  AW  requester A address.
REQ-008 a_wdata  input  8  requester A write data.
REQ-009 a_ack  output  1  one-cycle completion pulse to A.
REQ-010 a_rdata  output  8  registered read data to A.
REQ-011 b_req, b_wr, b_addr, b_wdata, b_ack, b_rdata SHALL exist for requester B (loader/DMA side), with widths and meanings identical to the A ports.
REQ-012 ram_addr  output  AW  RAM address.
REQ-013 ram_wdata  output  8  RAM write data.
REQ-014 ram_ce  output  1  RAM chip enable.
REQ-015 ram_rden  output  1  RAM read strobe.
REQ-016 ram_wren  output  1  RAM write strobe.
REQ-017 ram_q  input  8  RAM read data.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ACCESS, RWAIT and ACK.
REQ-020 In IDLE with no request pending, the FSM SHALL remain in IDLE and drive ram_ce, ram_rden and ram_wren to 0.
REQ-021 In IDLE with a request pending, the FSM SHALL select one requester, register its wr/addr/wdata plus the grant identity, and enter ACCESS on the next edge.
REQ-022 When only one requester is active, arbitration SHALL select it.
REQ-023 When both requesters are active, arbitration SHALL select the requester not granted last (round-robin); the pointer SHALL update only on grant.
REQ-024 ACCESS SHALL last exactly 1 cycle with ram_ce=1, ram_rden=~wr, ram_wren=wr, and ram_addr/ram_wdata taken from the registered values.
REQ-025 ram_addr and ram_wdata SHALL hold their last values outside ACCESS.
REQ-026 After a write ACCESS, the FSM SHALL go to ACK.
REQ-027 After a read ACCESS, the FSM SHALL go to RWAIT.
REQ-028 RWAIT SHALL last RD_LAT cycles, counted by a 2-bit counter.
REQ-029 On the final RWAIT edge, the block SHALL capture ram_q into the granted requester's rdata, then enter ACK.
REQ-030 x_rdata SHALL change only on that requester's read completion.
REQ-031 ACK SHALL last 1 cycle with x_ack=1 for the granted requester only, then return to IDLE.
REQ-032 a_ack and b_ack SHALL never be high in the same cycle.
REQ-033 Latency SHALL be measured from the IDLE edge that samples req to ack high: write = 2 cycles; read = 2+RD_LAT cycles.
REQ-034 Requester handshake: the requester SHALL deassert req in the cycle after it sees ack; a req still high in the following IDLE SHALL be treated as a new request.
REQ-035 Changes on the granted requester's wr/addr/wdata after grant SHALL be ignored.
REQ-036 A request arriving while the FSM is not in IDLE SHALL wait; no request SHALL be dropped.
REQ-037 With both requesters continuously active, grants SHALL strictly alternate A, B, A, B...

Reset
REQ-038 When n_rst is low, the block SHALL immediately force: state=IDLE, ram_ce=ram_rden=ram_wren=0, a_ack=b_ack=0, a_rdata=b_rdata=8'h00, ram_addr=0, ram_wdata=8'h00, busy=0, RWAIT counter=0.
REQ-039 Reset SHALL initialise the round-robin pointer so that A wins the first simultaneous request.
REQ-040 Reset asserted mid-access SHALL abort the transfer with no ack issued; after release, still-held requests SHALL be re-arbitrated from IDLE.

Verification
REQ-041 A-only write, addr 0x1234, data 0x5A -> one ACCESS cycle with ram_wren=1, ram_addr=0x1234, ram_wdata=0x5A; a_ack 2 cycles after sampling; b_ack stays 0.
REQ-042 B-only read with RD_LAT=1 and RAM model returning 0xC3 -> b_rdata=0xC3 and b_ack high 3 cycles after sampling; a_rdata unchanged.
REQ-043 a_req and b_req rising in the same cycle after reset, both held for 4 transactions -> grant order A, B, A, B, with ack pulses never overlapping.
REQ-044 RD_LAT=3 read -> RWAIT 3 cycles; ram_q sampled only on the 3rd cycle (bench drives garbage before it).
REQ-045 n_rst pulsed low during RWAIT -> all outputs zero immediately, no ack; after release a held a_req completes normally.
REQ-046 A's addr changed in the cycle after grant -> RAM still sees the originally sampled address.
